// File: rtl/sonar_ping_echo.sv
// sonar_ping_echo: sonar ping/echo controller.
// Emits a tone burst on the speaker, blanks transducer ring-down, then scans the
// filtered sample stream for the first return at or above threshold and reports
// its time of flight (or a timeout when the listen window closes empty).
// Optional feature macro: SONAR_PEAK_HOLD_EN -- when defined, the reported echo is
// the largest sample of the first above-threshold run instead of the first crossing.
module sonar_ping_echo #(
  parameter int unsigned DIV        = 16,
  parameter int unsigned BURST_CYC  = 7,
  parameter int unsigned BLANK_CYC  = 64,
  parameter int unsigned WINDOW_CYC = 40000,
  parameter int unsigned PERIOD_CYC = 65535,
  parameter int unsigned SW         = 21,
  parameter int unsigned TW         = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start_i,
  input  logic                 auto_en_i,
  input  logic [SW-2:0]        threshold_i,
  input  logic signed [SW-1:0] smp_data_i,
  input  logic                 smp_valid_i,
  output logic                 speaker_o,
  output logic                 tx_active_o,
  output logic                 busy_o,
  output logic                 echo_valid_o,
  output logic [TW-1:0]        echo_time_o,
  output logic [SW-2:0]        echo_peak_o,
  output logic                 timeout_o
);

  localparam int unsigned PW        = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int unsigned HALF      = DIV / 2;
  localparam int unsigned BURST_END = BURST_CYC * DIV - 1;
  localparam int unsigned BLANK_END = BURST_CYC * DIV + BLANK_CYC - 1;
  localparam int unsigned WIN_END   = WINDOW_CYC - 1;
  localparam int unsigned HOLD_END  = PERIOD_CYC - 1;
  localparam logic [SW-1:0] SMP_MIN = {1'b1, {(SW-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_BURST,
    S_BLANK,
    S_LISTEN,
    S_HOLD
  } state_t;

  state_t          state_q;
  logic [TW-1:0]   timer_q;
  logic [TW-1:0]   timer_d;
  logic [PW-1:0]   phase_q;
  logic [PW-1:0]   phase_d;
  logic            speaker_q;
  logic            tx_active_q;
  logic            busy_q;
  logic            echo_valid_q;
  logic [TW-1:0]   echo_time_q;
  logic [SW-2:0]   echo_peak_q;
  logic            timeout_q;

  logic [SW-1:0]   smp_neg_c;
  logic [SW-2:0]   mag_c;
  logic            hit_c;
  logic            win_end_c;

`ifdef SONAR_PEAK_HOLD_EN
  logic            pk_act_q;
  logic [SW-2:0]   pk_mag_q;
  logic [TW-1:0]   pk_time_q;
  logic            below_c;
  logic            better_c;
`endif

  // Sample magnitude; the most-negative code has no positive twin, so saturate it.
  always_comb begin
    smp_neg_c = -smp_data_i;
    if (smp_data_i == SMP_MIN) begin
      mag_c = '1;
    end else if (smp_data_i[SW-1]) begin
      mag_c = smp_neg_c[SW-2:0];
    end else begin
      mag_c = smp_data_i[SW-2:0];
    end
  end

  // Crossing / window-end qualifiers and counter successors.
  always_comb begin
    hit_c     = smp_valid_i && (mag_c >= threshold_i);
    win_end_c = (timer_q == TW'(WIN_END));
    timer_d   = timer_q + TW'(1);
    phase_d   = (phase_q == PW'(DIV - 1)) ? '0 : phase_q + PW'(1);
`ifdef SONAR_PEAK_HOLD_EN
    below_c   = smp_valid_i && (mag_c < threshold_i);
    better_c  = hit_c && (mag_c > pk_mag_q);
`endif
  end

  // Ping sequencer: state, timer, tone phase and all registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      timer_q      <= '0;
      phase_q      <= '0;
      speaker_q    <= 1'b0;
      tx_active_q  <= 1'b0;
      busy_q       <= 1'b0;
      echo_valid_q <= 1'b0;
      echo_time_q  <= '0;
      echo_peak_q  <= '0;
      timeout_q    <= 1'b0;
`ifdef SONAR_PEAK_HOLD_EN
      pk_act_q     <= 1'b0;
      pk_mag_q     <= '0;
      pk_time_q    <= '0;
`endif
    end else begin
      echo_valid_q <= 1'b0;
      timeout_q    <= 1'b0;
      if (state_q != S_IDLE) begin
        timer_q <= timer_d;
      end

      case (state_q)
        S_IDLE: begin
          if (start_i || auto_en_i) begin
            state_q     <= S_BURST;
            timer_q     <= '0;
            phase_q     <= '0;
            speaker_q   <= 1'b1;
            tx_active_q <= 1'b1;
            busy_q      <= 1'b1;
`ifdef SONAR_PEAK_HOLD_EN
            pk_act_q    <= 1'b0;
`endif
          end
        end

        S_BURST: begin
          if (timer_q == TW'(BURST_END)) begin
            state_q     <= S_BLANK;
            speaker_q   <= 1'b0;
            tx_active_q <= 1'b0;
          end else begin
            phase_q   <= phase_d;
            speaker_q <= (phase_d < PW'(HALF));
          end
        end

        S_BLANK: begin
          if (timer_q == TW'(BLANK_END)) begin
            state_q <= S_LISTEN;
          end
        end

        S_LISTEN: begin
`ifdef SONAR_PEAK_HOLD_EN
          if (!pk_act_q) begin
            if (hit_c && win_end_c) begin
              echo_valid_q <= 1'b1;
              echo_time_q  <= timer_q;
              echo_peak_q  <= mag_c;
              state_q      <= S_HOLD;
            end else if (hit_c) begin
              pk_act_q  <= 1'b1;
              pk_mag_q  <= mag_c;
              pk_time_q <= timer_q;
            end else if (win_end_c) begin
              timeout_q <= 1'b1;
              state_q   <= S_HOLD;
            end
          end else if (below_c || win_end_c) begin
            // Run ended: report the best sample, including one arriving right now.
            echo_valid_q <= 1'b1;
            echo_time_q  <= better_c ? timer_q : pk_time_q;
            echo_peak_q  <= better_c ? mag_c : pk_mag_q;
            pk_act_q     <= 1'b0;
            state_q      <= S_HOLD;
          end else if (better_c) begin
            pk_mag_q  <= mag_c;
            pk_time_q <= timer_q;
          end
`else
          if (hit_c) begin
            echo_valid_q <= 1'b1;
            echo_time_q  <= timer_q;
            echo_peak_q  <= mag_c;
            state_q      <= S_HOLD;
          end else if (win_end_c) begin
            timeout_q <= 1'b1;
            state_q   <= S_HOLD;
          end
`endif
        end

        S_HOLD: begin
          // >= guards the case where the window already ran past the period end.
          if (timer_q >= TW'(HOLD_END)) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end

        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign speaker_o    = speaker_q;
  assign tx_active_o  = tx_active_q;
  assign busy_o       = busy_q;
  assign echo_valid_o = echo_valid_q;
  assign echo_time_o  = echo_time_q;
  assign echo_peak_o  = echo_peak_q;
  assign timeout_o    = timeout_q;

endmodule
